// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte streams plus the shared UART TX write port.
interface uart_tx_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]       in_valid;
    logic [N_REQ-1:0]       in_last;
    logic [N_REQ*WIDTH-1:0] in_data;
    logic [N_REQ-1:0]       in_ready;
    logic [WIDTH-1:0]       w_data;
    logic                   wr_uart;
    logic                   tx_fifo_full;
    modport master (
        input  in_valid, in_last, in_data, tx_fifo_full,
        output in_ready, w_data, wr_uart
    );
    modport slave (
        output in_valid, in_last, in_data, tx_fifo_full,
        input  in_ready, w_data, wr_uart
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-atomic sharing of the UART TX write port.
module uart_tx_arbiter #(
    parameter int WIDTH   = 8,
    parameter int N_REQ   = 4,
    parameter int MAX_LEN = 16,
    localparam int IW     = $clog2(N_REQ),
    localparam int CW     = $clog2(MAX_LEN)
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_arbiter_if.master    bus,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic                 ovf,
    output logic [IW-1:0]        ovf_id
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t           state_q;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    ptr_q, ovf_id_q, g_idx, win_idx;
    logic [CW-1:0]    cnt_q;
    logic             ovf_q, xfer, at_max;
    always_comb begin
        g_idx   = '0;
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grant_q[i]) g_idx = IW'(i);
        // Scan from the farthest offset down so the nearest requester after ptr wins.
        for (int k = N_REQ; k >= 1; k--)
            if (bus.in_valid[(int'(ptr_q) + k) % N_REQ]) win_idx = IW'((int'(ptr_q) + k) % N_REQ);
        grant_d = N_REQ'(1) << win_idx;
    end
    assign xfer         = (state_q == GRANT) && bus.in_valid[g_idx] && !bus.tx_fifo_full;
    assign at_max       = cnt_q == CW'(MAX_LEN - 1);
    assign bus.in_ready = (state_q == GRANT && !bus.tx_fifo_full) ? grant_q : '0;
    assign bus.wr_uart  = xfer;
    assign bus.w_data   = bus.in_data[g_idx*WIDTH +: WIDTH];
    assign grant        = grant_q;
    assign busy         = state_q == GRANT;
    assign ovf          = ovf_q;
    assign ovf_id       = ovf_id_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ptr_q    <= IW'(N_REQ - 1);
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            ovf_id_q <= '0;
        end else begin
            ovf_q <= 1'b0;
            if (state_q == IDLE) begin
                cnt_q <= '0;
                if (|bus.in_valid) begin
                    state_q <= GRANT;
                    grant_q <= grant_d;
                end
            end else if (xfer) begin
                cnt_q <= cnt_q + CW'(1);
                if (bus.in_last[g_idx] || at_max) begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    ptr_q   <= g_idx;
                    if (!bus.in_last[g_idx]) begin
                        ovf_q    <= 1'b1;
                        ovf_id_q <= g_idx;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios with reactive requester queues and a transfer log.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    uart_tx_arbiter_if #(.WIDTH(8), .N_REQ(4)) bus ();
    logic [3:0] grant;
    logic       busy, ovf;
    logic [1:0] ovf_id;
    uart_tx_arbiter #(.WIDTH(8), .N_REQ(4), .MAX_LEN(16)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .grant(grant), .busy(busy), .ovf(ovf), .ovf_id(ovf_id)
    );
    int errors = 0, checks = 0;
    logic [7:0] q_d [4][32];
    logic       q_l [4][32];
    int         q_hd [4], q_n [4];
    logic [3:0] tr_grant [64], tr_rdy [64];
    logic       tr_busy [64], tr_wr [64], tr_ovf [64];
    logic [1:0] tr_ovfid [64];
    logic [7:0] log_d [64];
    int         log_id [64];
    int         log_n, ff_lo, ff_hi;

    task automatic push(input int i, input logic [7:0] d, input logic l);
        q_d[i][q_n[i]] = d;
        q_l[i][q_n[i]] = l;
        q_n[i]++;
    endtask

    task automatic clear_q();
        for (int i = 0; i < 4; i++) begin
            q_hd[i] = 0;
            q_n[i]  = 0;
        end
    endtask

    task automatic drive(input int t);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid[i]       = q_hd[i] < q_n[i];
            bus.in_data[i*8 +: 8] = bus.in_valid[i] ? q_d[i][q_hd[i] & 31] : 8'h00;
            bus.in_last[i]        = bus.in_valid[i] ? q_l[i][q_hd[i] & 31] : 1'b0;
        end
        bus.tx_fifo_full = (t >= ff_lo) && (t < ff_hi);
    endtask

    task automatic run(input int n);
        log_n = 0;
        for (int t = 0; t < n; t++) begin
            drive(t);
            @(negedge clk);
            tr_grant[t] = grant;
            tr_rdy[t]   = bus.in_ready;
            tr_busy[t]  = busy;
            tr_wr[t]    = bus.wr_uart;
            tr_ovf[t]   = ovf;
            tr_ovfid[t] = ovf_id;
            if (bus.wr_uart && log_n < 64) begin
                log_d[log_n]  = bus.w_data;
                log_id[log_n] = -1;
                for (int i = 0; i < 4; i++) if (grant[i]) log_id[log_n] = i;
                log_n++;
            end
            for (int i = 0; i < 4; i++) if (bus.in_valid[i] && bus.in_ready[i]) q_hd[i]++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_q();
        ff_lo = 0;
        ff_hi = 0;
        drive(0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset            = 1'b0;
        bus.in_valid     = 4'b0000;
        bus.in_last      = 4'b0000;
        bus.in_data      = 32'h44332211;
        bus.tx_fifo_full = 1'b0;
        #12;
        checks += 7;
        if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (bus.wr_uart !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b expected 0", bus.wr_uart); end
        if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", bus.in_ready); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        if (ovf_id !== 2'd0) begin errors++; $display("FAIL reset_ovf_id: got %0d expected 0", ovf_id); end
        if (bus.w_data !== 8'h11) begin errors++; $display("FAIL reset_wdata: got %h expected 11", bus.w_data); end
    endtask

    task automatic test_single();
        logic [7:0] exp_d [3] = '{8'hA1, 8'hA2, 8'hA3};
        do_reset();
        push(1, 8'hA1, 1'b0);
        push(1, 8'hA2, 1'b0);
        push(1, 8'hA3, 1'b1);
        run(6);
        checks += 4;
        if (tr_grant[0] !== 4'b0000) begin errors++; $display("FAIL single_grant0: got %b expected 0000", tr_grant[0]); end
        if (tr_grant[1] !== 4'b0010) begin errors++; $display("FAIL single_grant1: got %b expected 0010", tr_grant[1]); end
        if (tr_busy[4] !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b expected 0", tr_busy[4]); end
        if (tr_rdy[1] !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b expected 0010", tr_rdy[1]); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (tr_wr[k+1] !== 1'b1 || log_d[k] !== exp_d[k])
                begin errors++; $display("FAIL single_byte%0d: got wr=%b data=%h expected wr=1 data=%h", k, tr_wr[k+1], log_d[k], exp_d[k]); end
        end
        checks++;
        if (log_n !== 3) begin errors++; $display("FAIL single_count: got %0d expected 3", log_n); end
    endtask

    task automatic test_contention();
        logic [7:0] exp_d [6] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13};
        int         exp_i [6] = '{0, 0, 2, 2, 0, 0};
        do_reset();
        push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1);
        push(0, 8'h12, 1'b0); push(0, 8'h13, 1'b1);
        push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b1);
        run(11);
        checks += 5;
        if (tr_grant[1] !== 4'b0001) begin errors++; $display("FAIL cont_grant_first: got %b expected 0001", tr_grant[1]); end
        if (tr_rdy[1] !== 4'b0001) begin errors++; $display("FAIL cont_ready_other: got %b expected 0001", tr_rdy[1]); end
        if (tr_grant[3] !== 4'b0000) begin errors++; $display("FAIL cont_idle_gap: got %b expected 0000", tr_grant[3]); end
        if (tr_grant[4] !== 4'b0100) begin errors++; $display("FAIL cont_grant_second: got %b expected 0100", tr_grant[4]); end
        if (tr_grant[7] !== 4'b0001) begin errors++; $display("FAIL cont_grant_third: got %b expected 0001", tr_grant[7]); end
        checks++;
        if (log_n !== 6) begin errors++; $display("FAIL cont_count: got %0d expected 6", log_n); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (log_d[k] !== exp_d[k] || log_id[k] !== exp_i[k])
                begin errors++; $display("FAIL cont_byte%0d: got %h from %0d expected %h from %0d", k, log_d[k], log_id[k], exp_d[k], exp_i[k]); end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int m = 0; m < 3; m++)
            for (int i = 0; i < 4; i++) push(i, 8'(16*i + m), 1'b1);
        run(25);
        checks++;
        if (log_n !== 12) begin errors++; $display("FAIL rr_count: got %0d expected 12", log_n); end
        for (int k = 0; k < 12; k++) begin
            checks += 3;
            if (tr_busy[2*k] !== 1'b0) begin errors++; $display("FAIL rr_idle%0d: got busy=%b expected 0", k, tr_busy[2*k]); end
            if (tr_grant[2*k+1] !== 4'(1 << (k % 4)))
                begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, tr_grant[2*k+1], 4'(1 << (k % 4))); end
            if (log_d[k] !== 8'(16*(k % 4) + k / 4))
                begin errors++; $display("FAIL rr_byte%0d: got %h expected %h", k, log_d[k], 8'(16*(k % 4) + k / 4)); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 10; k++) push(3, 8'(8'h30 + k), k == 9);
        ff_lo = 4;
        ff_hi = 9;
        run(18);
        for (int t = 4; t < 9; t++) begin
            checks++;
            if (tr_rdy[t] !== 4'b0000 || tr_wr[t] !== 1'b0)
                begin errors++; $display("FAIL bp_stall%0d: got ready=%b wr=%b expected ready=0000 wr=0", t, tr_rdy[t], tr_wr[t]); end
        end
        checks += 3;
        if (tr_wr[3] !== 1'b1) begin errors++; $display("FAIL bp_pre_stall: got wr=%b expected 1", tr_wr[3]); end
        if (tr_busy[16] !== 1'b0) begin errors++; $display("FAIL bp_release: got busy=%b expected 0", tr_busy[16]); end
        if (log_n !== 10) begin errors++; $display("FAIL bp_count: got %0d expected 10", log_n); end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (log_d[k] !== 8'(8'h30 + k) || log_id[k] !== 3)
                begin errors++; $display("FAIL bp_byte%0d: got %h from %0d expected %h from 3", k, log_d[k], log_id[k], 8'(8'h30 + k)); end
        end
    endtask

    task automatic test_overlength();
        do_reset();
        for (int k = 0; k < 20; k++) push(2, 8'(8'h40 + k), k == 19);
        run(24);
        checks += 9;
        if (tr_ovf[16] !== 1'b0) begin errors++; $display("FAIL ovl_ovf_early: got %b expected 0", tr_ovf[16]); end
        if (tr_ovf[17] !== 1'b1) begin errors++; $display("FAIL ovl_ovf_pulse: got %b expected 1", tr_ovf[17]); end
        if (tr_ovfid[17] !== 2'd2) begin errors++; $display("FAIL ovl_ovf_id: got %0d expected 2", tr_ovfid[17]); end
        if (tr_ovf[18] !== 1'b0) begin errors++; $display("FAIL ovl_ovf_width: got %b expected 0", tr_ovf[18]); end
        if (tr_grant[17] !== 4'b0000) begin errors++; $display("FAIL ovl_release: got %b expected 0000", tr_grant[17]); end
        if (tr_grant[18] !== 4'b0100) begin errors++; $display("FAIL ovl_regrant: got %b expected 0100", tr_grant[18]); end
        if (tr_ovf[22] !== 1'b0) begin errors++; $display("FAIL ovl_no_ovf_last: got %b expected 0", tr_ovf[22]); end
        if (tr_ovfid[22] !== 2'd2) begin errors++; $display("FAIL ovl_id_hold: got %0d expected 2", tr_ovfid[22]); end
        if (log_n !== 20) begin errors++; $display("FAIL ovl_count: got %0d expected 20", log_n); end
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (log_d[k] !== 8'(8'h40 + k))
                begin errors++; $display("FAIL ovl_byte%0d: got %h expected %h", k, log_d[k], 8'(8'h40 + k)); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(0, 8'h5F, 1'b1);
        for (int k = 0; k < 5; k++) push(0, 8'(8'h60 + k), k == 4);
        run(4);
        drive(4);
        #2;
        checks++;
        if (bus.wr_uart !== 1'b1 || bus.w_data !== 8'h61)
            begin errors++; $display("FAIL rmid_pre: got wr=%b data=%h expected wr=1 data=61", bus.wr_uart, bus.w_data); end
        reset = 1'b0;
        #1;
        checks += 4;
        if (grant !== 4'b0000) begin errors++; $display("FAIL rmid_grant: got %b expected 0000", grant); end
        if (bus.wr_uart !== 1'b0) begin errors++; $display("FAIL rmid_wr: got %b expected 0", bus.wr_uart); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL rmid_ready: got %b expected 0000", bus.in_ready); end
        @(posedge clk);
        @(negedge clk);
        clear_q();
        push(1, 8'h71, 1'b1);
        for (int k = 0; k < 5; k++) push(0, 8'(8'h60 + k), k == 4);
        drive(0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        run(10);
        checks += 4;
        if (tr_grant[1] !== 4'b0001) begin errors++; $display("FAIL rmid_priority: got %b expected 0001", tr_grant[1]); end
        if (log_d[0] !== 8'h60 || log_id[0] !== 0)
            begin errors++; $display("FAIL rmid_first: got %h from %0d expected 60 from 0", log_d[0], log_id[0]); end
        if (log_n !== 6) begin errors++; $display("FAIL rmid_count: got %0d expected 6", log_n); end
        if (log_d[5] !== 8'h71 || log_id[5] !== 1)
            begin errors++; $display("FAIL rmid_next: got %h from %0d expected 71 from 1", log_d[5], log_id[5]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_round_robin();
        test_backpressure();
        test_overlength();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single transmit write port of the UART core (`w_data`/`wr_uart`/`tx_fifo_full`) among `N_REQ` byte-stream requesters. Each requester sends whole messages (a burst of bytes terminated by `in_last`). Bytes of different messages are never interleaved in the TX FIFO. The block sits between on-chip message sources and `uart_top`, and applies backpressure from `tx_fifo_full` to the granted requester.

## Interface

**Parameters**
- `WIDTH`, 8: data byte width; must match `uart_top` `WIDTH`.
- `N_REQ`, 4: number of requesters, 2..8.
- `MAX_LEN`, 16: maximum bytes per message before forced release, 2..256.

**Ports**
- `clk`, in, 1: system clock (same clock as `uart_top`).
- `reset`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, `N_REQ`: requester *i* has a byte on its data slice.
- `in_last`, in, `N_REQ`: the byte from requester *i* is the final byte of its message.
- `in_data`, in, `N_REQ*WIDTH`: requester *i* byte on bits [`i*WIDTH +: WIDTH`].
- `in_ready`, out, `N_REQ`: byte from requester *i* is accepted this cycle.
- `w_data`, out, `WIDTH`: byte to `uart_top.w_data`.
- `wr_uart`, out, 1: write strobe to `uart_top.wr_uart`.
- `tx_fifo_full`, in, 1: from `uart_top.tx_fifo_full`.
- `grant`, out, `N_REQ`: one-hot owner of the port; all zero when idle.
- `busy`, out, 1: a message is in progress (state GRANT).
- `ovf`, out, 1: one-cycle pulse when a message is force-released at `MAX_LEN`.
- `ovf_id`, out, `clog2(N_REQ)`: index of the requester that caused `ovf`; holds its value until the next `ovf`.

## Operation

**State machine:** IDLE, GRANT.

**IDLE**
- `grant` = 0 and `in_ready` = 0.
- If any `in_valid` bit is set, the winner is the first set bit searched from `ptr+1` upward, wrapping modulo `N_REQ`.
- The winner is registered into `grant`, and the state moves to GRANT.
- Byte counter `cnt` is cleared.

**GRANT (owner g)**
- `in_ready[g]` = `!tx_fifo_full`. Every other `in_ready` bit is 0.
- A transfer occurs when `in_valid[g] && in_ready[g]`.
- `wr_uart` = transfer, combinational from state and inputs.
- `w_data` = `in_data` slice g. When there is no transfer, `w_data` still shows slice g; it is don't-care to the FIFO.
- Each transfer increments `cnt` (width `clog2(MAX_LEN)`).
- The message ends when a transfer occurs with `in_last[g]` set, or with `cnt == MAX_LEN-1`. At end of message:
  - `ptr` ← g;
  - state → IDLE;
  - `grant` clears next cycle.
- Forced end (`cnt == MAX_LEN-1` and `!in_last[g]`): `ovf` pulses high the next cycle and `ovf_id` ← g. The requester's remaining bytes form a new message that competes normally.
- If `in_valid[g]` drops mid-message, the grant is held indefinitely. There is no timeout.

**Boundary rules**
- `tx_fifo_full` high: no transfer and no `cnt` change. `wr_uart` is never asserted while full.
- Single requester continuously valid: it is re-granted after one IDLE cycle, so each message costs +1 cycle.
- `ptr` reset value is `N_REQ-1`, so requester 0 has first priority after reset.
- A 1-byte message (`in_last` on the first byte) is legal.
- `in_valid` on non-granted requesters is ignored, with `in_ready` = 0. Requesters must hold data until accepted.

**Reset (asynchronous, `reset` = 0)**
- State = IDLE, `grant` = 0, `ptr` = `N_REQ-1`, `cnt` = 0, `ovf` = 0, `ovf_id` = 0.
- Outputs: `busy` = 0, `wr_uart` = 0, `in_ready` = 0.
- `w_data` = `in_data` slice 0 (don't-care).
- Reset mid-message drops the message. The UART FIFO is reset by the same `reset` net.

## Timing

- Arbitration latency is 1 cycle: `in_valid` seen in IDLE at edge *k*; `grant`/`busy` high after edge *k*; the first transfer can happen in cycle *k+1*.
- Throughput is 1 byte/cycle within a message while the FIFO is not full.
- Message turnaround is 1 IDLE cycle after the last-byte transfer.
- Path `tx_fifo_full` → `in_ready`/`wr_uart` is combinational.
- `uart_top` must assert `tx_fifo_full` in the cycle after the write that fills it. With that timing, no write is ever lost.

## Test plan

- **Single requester:** requester 1 sends 3 bytes 0xA1, 0xA2, 0xA3, with last on 0xA3.
  - `grant` = 0010 one cycle after valid.
  - Three consecutive `wr_uart` pulses, with `w_data` A1, A2, A3.
  - `busy` falls after A3.
  - `tx` shows the 3 frames in order.
- **Contention:** requesters 0 and 2 each hold a 2-byte message from reset.
  - Grant order: 0 then 2.
  - FIFO content: 0's bytes, then 2's bytes, with no interleave.
  - Requester 0 asserting valid again right after is granted only after 2 finishes.
- **Round-robin rotation:** all 4 requesters continuously valid with 1-byte messages.
  - Grant sequence is 0, 1, 2, 3, 0, ….
  - One IDLE cycle between each grant.
- **Backpressure:** during a 10-byte message from requester 3, hold `tx_fifo_full` = 1 for 5 cycles mid-stream.
  - `in_ready[3]` = 0 and `wr_uart` = 0 throughout.
  - No byte is lost or duplicated.
  - Byte order is intact.
- **Overlength:** with `MAX_LEN` = 16, requester 2 sends 20 bytes with no last until byte 20.
  - Release after byte 16.
  - `ovf` pulses for 1 cycle with `ovf_id` = 2.
  - The remaining 4 bytes are sent as a new grant.
- **Reset mid-message:** assert `reset` low asynchronously (between clock edges) during byte 2 of 5.
  - Immediately `grant` = 0, `wr_uart` = 0, `busy` = 0.
  - After release, requester 0 has priority.
